// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: ALU opcode encodings, execute-stage FSM
// states, multiplier step count and the single-cycle ALU function.
package cpu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'h0,
        ALU_NOOP = 3'h1,
        ALU_SUB  = 3'h2,
        ALU_AND  = 3'h3,
        ALU_OR   = 3'h4,
        ALU_SLT  = 3'h5,
        ALU_MUL  = 3'h6,
        ALU_XOR  = 3'h7
    } alu_op_e;

    typedef enum logic {
        EX_IDLE = 1'b0,
        EX_BUSY = 1'b1
    } ex_state_e;

    localparam int MUL_STEPS = 32;

    // Single-cycle ALU; NOOP and MUL yield zero here (MUL has its own datapath).
    function automatic logic [31:0] alu_compute(input alu_op_e op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        res;
        sa  = a;
        sb  = b;
        res = 32'h0;
        case (op)
            ALU_ADD: res = a + b;
            ALU_SUB: res = a - b;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_SLT: res = (sa < sb) ? 32'h1 : 32'h0;
            ALU_XOR: res = a ^ b;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/execute_multiplier.sv
// Iterative 32-step shift-add multiplier for the execute stage.
// result presents the value after the step currently in progress, so the
// parent can capture the finished product on the edge of the last step.
module execute_multiplier
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic [4:0]  count,
    output logic [31:0] result
);

    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;

    assign result = acc + (mplier[0] ? mcand : 32'h0);

    // Step counter and busy flag; reset abandons any multiply in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= 1'b0;
            count <= 5'd0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= 5'd0;
        end else if (busy) begin
            count <= count + 5'd1;
            if (count == 5'(MUL_STEPS - 1)) begin
                busy <= 1'b0;
            end
        end
    end

    // Shift-add datapath: one multiplier bit consumed per cycle.
    always_ff @(posedge clk) begin
        if (start) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= 32'h0;
        end else if (busy) begin
            acc    <= result;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU, branch/jump resolution and the execute/memory register.
// Build option: define EXECUTE_MUL_EN to include the iterative multiplier,
// its BUSY state and the front-end stall; without it alu_op=6 is a NOOP.
module execute_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_value,
    input  logic [31:0] read_data_0,
    input  logic [31:0] read_data_1,
    input  logic [31:0] immediate,
    input  logic [2:0]  alu_op,
    input  logic        alu_src,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        mem_reg,
    input  logic        branch,
    input  logic        jump,
    input  logic        reg_dst,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    output logic [31:0] xm_alu_result,
    output logic [31:0] xm_store_data,
    output logic [4:0]  xm_write_addr,
    output logic        xm_mem_read,
    output logic        xm_mem_write,
    output logic        xm_reg_write,
    output logic        xm_mem_reg,
    output logic        xm_valid,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        stall
);

    logic        squash;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic [31:0] target_c;
    logic [4:0]  dest_c;
    logic        noop_c;
    logic        ex_valid;
    logic        take_c;

    logic        mul_start;
    logic        mul_done;
    logic        in_busy;
    logic [31:0] mul_result;
    logic        mul_mem_read_q;
    logic        mul_mem_write_q;
    logic        mul_reg_write_q;
    logic        mul_mem_reg_q;
    logic [31:0] mul_store_q;
    logic [4:0]  mul_addr_q;

    // A redirect issued last cycle kills whatever instruction is in execute now.
    assign squash   = branch_taken;
    assign op_b     = alu_src ? immediate : read_data_1;
    assign alu_res  = alu_compute(alu_op_e'(alu_op), read_data_0, op_b);
    assign dest_c   = reg_dst ? rd_addr : rt_addr;
    assign target_c = jump ? {pc_value[31:28], immediate[25:0], 2'b00}
                           : pc_value + (immediate << 2);
    // MUL never completes in a single cycle, so it is a bubble on the direct path.
    assign noop_c   = (alu_op == ALU_NOOP) || (alu_op == ALU_MUL);
    assign ex_valid = !squash && !noop_c;
    assign take_c   = !squash && !mul_start &&
                      (jump || (branch && (read_data_0 == read_data_1)));

`ifdef EXECUTE_MUL_EN
    ex_state_e   state_q;
    ex_state_e   state_d;
    logic        mul_busy;
    logic [4:0]  mul_count;

    execute_multiplier u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .op_a   (read_data_0),
        .op_b   (op_b),
        .busy   (mul_busy),
        .count  (mul_count),
        .result (mul_result)
    );

    assign in_busy  = (state_q == EX_BUSY);
    assign mul_done = in_busy && mul_busy && (mul_count == 5'(MUL_STEPS - 1));

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, multiply start and front-end stall.
    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        stall     = 1'b0;
        case (state_q)
            EX_IDLE: begin
                if ((alu_op == ALU_MUL) && !squash) begin
                    mul_start = 1'b1;
                    stall     = 1'b1;
                    state_d   = EX_BUSY;
                end
            end
            EX_BUSY: begin
                if (mul_done) begin
                    state_d = EX_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = EX_IDLE;
        endcase
    end

    // Capture the multiply's controls and destination when it starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_mem_read_q  <= 1'b0;
            mul_mem_write_q <= 1'b0;
            mul_reg_write_q <= 1'b0;
            mul_mem_reg_q   <= 1'b0;
            mul_store_q     <= 32'h0;
            mul_addr_q      <= 5'd0;
        end else if (mul_start) begin
            mul_mem_read_q  <= mem_read;
            mul_mem_write_q <= mem_write;
            mul_reg_write_q <= reg_write;
            mul_mem_reg_q   <= mem_reg;
            mul_store_q     <= read_data_1;
            mul_addr_q      <= dest_c;
        end
    end
`else
    assign mul_start       = 1'b0;
    assign mul_done        = 1'b0;
    assign in_busy         = 1'b0;
    assign mul_result      = 32'h0;
    assign mul_mem_read_q  = 1'b0;
    assign mul_mem_write_q = 1'b0;
    assign mul_reg_write_q = 1'b0;
    assign mul_mem_reg_q   = 1'b0;
    assign mul_store_q     = 32'h0;
    assign mul_addr_q      = 5'd0;
    assign stall           = 1'b0;
`endif

    // Execute/memory register: direct ALU path when idle, multiply path when busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xm_alu_result <= 32'h0;
            xm_store_data <= 32'h0;
            xm_write_addr <= 5'd0;
            xm_mem_read   <= 1'b0;
            xm_mem_write  <= 1'b0;
            xm_reg_write  <= 1'b0;
            xm_mem_reg    <= 1'b0;
            xm_valid      <= 1'b0;
            branch_taken  <= 1'b0;
            branch_target <= 32'h0;
        end else if (in_busy) begin
            xm_valid     <= mul_done;
            xm_mem_read  <= mul_done && mul_mem_read_q;
            xm_mem_write <= mul_done && mul_mem_write_q;
            xm_reg_write <= mul_done && mul_reg_write_q;
            xm_mem_reg   <= mul_done && mul_mem_reg_q;
            branch_taken <= 1'b0;
            if (mul_done) begin
                xm_alu_result <= mul_result;
                xm_store_data <= mul_store_q;
                xm_write_addr <= mul_addr_q;
            end
        end else begin
            xm_valid      <= ex_valid;
            xm_mem_read   <= ex_valid && mem_read;
            xm_mem_write  <= ex_valid && mem_write;
            xm_reg_write  <= ex_valid && reg_write;
            xm_mem_reg    <= ex_valid && mem_reg;
            xm_alu_result <= alu_res;
            xm_store_data <= read_data_1;
            xm_write_addr <= dest_c;
            branch_taken  <= take_c;
            branch_target <= target_c;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: the driver acts as the decode/execute
// register (holding its instruction while stall is high) and pushes the
// expected XM contents for each cycle; a monitor pops and compares them.
module tb_execute_stage;

`ifdef EXECUTE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_value = 32'h0, read_data_0 = 32'h0, read_data_1 = 32'h0, immediate = 32'h0;
    logic [2:0]  alu_op = 3'd1;
    logic        alu_src = 1'b0, mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0;
    logic        mem_reg = 1'b0, branch = 1'b0, jump = 1'b0, reg_dst = 1'b0;
    logic [4:0]  rt_addr = 5'd0, rd_addr = 5'd0;
    logic [31:0] xm_alu_result, xm_store_data, branch_target;
    logic [4:0]  xm_write_addr;
    logic        xm_mem_read, xm_mem_write, xm_reg_write, xm_mem_reg, xm_valid;
    logic        branch_taken, stall;

    execute_stage dut (
        .clk(clk), .rst(rst), .pc_value(pc_value), .read_data_0(read_data_0),
        .read_data_1(read_data_1), .immediate(immediate), .alu_op(alu_op),
        .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem_reg(mem_reg), .branch(branch), .jump(jump),
        .reg_dst(reg_dst), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .xm_alu_result(xm_alu_result), .xm_store_data(xm_store_data),
        .xm_write_addr(xm_write_addr), .xm_mem_read(xm_mem_read),
        .xm_mem_write(xm_mem_write), .xm_reg_write(xm_reg_write),
        .xm_mem_reg(xm_mem_reg), .xm_valid(xm_valid), .branch_taken(branch_taken),
        .branch_target(branch_target), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc, rd0, rd1, imm;
        logic [2:0]  op;
        logic        src, mr, mw, rw, mreg, br, jmp, rdst;
        logic [4:0]  rt, rd;
    } instr_t;

    typedef struct packed {
        int          due;
        logic        valid, mr, mw, rw, mreg;
        logic [31:0] result, store;
        logic [4:0]  addr;
        logic        br;
        logic [31:0] target;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   m_taken = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the XM register against the expectation due this cycle.
    initial begin
        exp_t me;
        forever begin
            @(negedge clk);
            if (!rst && sbq.size() > 0 && sbq[0].due == cyc) begin
                me = sbq.pop_front();
                chk("ctrl{valid,mr,mw,rw,mreg}",
                    {27'd0, xm_valid, xm_mem_read, xm_mem_write, xm_reg_write, xm_mem_reg},
                    {27'd0, me.valid, me.mr, me.mw, me.rw, me.mreg});
                chk("branch_taken", {31'd0, branch_taken}, {31'd0, me.br});
                if (me.valid) begin
                    chk("xm_alu_result", xm_alu_result, me.result);
                    chk("xm_store_data", xm_store_data, me.store);
                    chk("xm_write_addr", {27'd0, xm_write_addr}, {27'd0, me.addr});
                end
                if (me.br) chk("branch_target", branch_target, me.target);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached before finish");
        $fatal(1);
    end

    task automatic apply(input instr_t i);
        pc_value = i.pc; read_data_0 = i.rd0; read_data_1 = i.rd1; immediate = i.imm;
        alu_op = i.op; alu_src = i.src; mem_read = i.mr; mem_write = i.mw;
        reg_write = i.rw; mem_reg = i.mreg; branch = i.br; jump = i.jmp;
        reg_dst = i.rdst; rt_addr = i.rt; rd_addr = i.rd;
    endtask

    // Reference behaviour of one instruction that finishes in one cycle.
    function automatic exp_t model_single(input instr_t i, input bit sq);
        exp_t        e;
        logic [31:0] b;
        logic        v;
        e = '0;
        if (sq) return e;
        b = i.src ? i.imm : i.rd1;
        case (i.op)
            3'd0: e.result = i.rd0 + b;
            3'd2: e.result = i.rd0 - b;
            3'd3: e.result = i.rd0 & b;
            3'd4: e.result = i.rd0 | b;
            3'd5: e.result = ($signed(i.rd0) < $signed(b)) ? 32'd1 : 32'd0;
            3'd7: e.result = i.rd0 ^ b;
            default: e.result = 32'd0;
        endcase
        v = (i.op != 3'd1) && (i.op != 3'd6);
        e.valid = v; e.mr = v & i.mr; e.mw = v & i.mw; e.rw = v & i.rw; e.mreg = v & i.mreg;
        e.store = i.rd1;
        e.addr  = i.rdst ? i.rd : i.rt;
        e.br    = i.jmp | (i.br & (i.rd0 == i.rd1));
        e.target = i.jmp ? {i.pc[31:28], i.imm[25:0], 2'b00} : i.pc + i.imm * 32'd4;
        return e;
    endfunction

    // Present one instruction, holding it for as long as the stage stalls.
    task automatic run_instr(input instr_t i);
        exp_t e;
        bit   sq;
        sq = m_taken;
        apply(i);
        if (MUL_EN && !sq && i.op == 3'd6) begin
            for (int c = 0; c <= 32; c++) begin
                e = '0;
                e.due = cyc + 1;
                if (c == 32) begin
                    e.valid = 1'b1; e.mr = i.mr; e.mw = i.mw; e.rw = i.rw; e.mreg = i.mreg;
                    e.result = i.rd0 * (i.src ? i.imm : i.rd1);
                    e.store  = i.rd1;
                    e.addr   = i.rdst ? i.rd : i.rt;
                end
                sbq.push_back(e);
                #1 chk("stall(mul)", {31'd0, stall}, (c < 32) ? 32'd1 : 32'd0);
                @(posedge clk); #1;
            end
            m_taken = 1'b0;
        end else begin
            e = model_single(i, sq);
            e.due = cyc + 1;
            sbq.push_back(e);
            #1 chk("stall", {31'd0, stall}, 32'd0);
            @(posedge clk); #1;
            m_taken = e.br;
        end
    endtask

    function automatic instr_t blank(input logic [2:0] op);
        instr_t i;
        i = '0;
        i.op = op;
        return i;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 15));
            1: return 32'hFFFFFFFF - 32'($urandom_range(0, 15));
            2: return 32'h80000000 ^ 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.pc  = $urandom;
        i.rd0 = pick();
        i.rd1 = ($urandom_range(0, 3) == 0) ? i.rd0 : pick();
        i.imm = ($urandom_range(0, 1) == 1) ? 32'($signed(16'($urandom))) : $urandom;
        i.op  = 3'($urandom_range(0, 7));
        if (i.op == 3'd6 && $urandom_range(0, 3) != 0) i.op = 3'd0;
        i.src = 1'($urandom); i.mr = 1'($urandom); i.mw = 1'($urandom);
        i.rw = 1'($urandom); i.mreg = 1'($urandom); i.rdst = 1'($urandom);
        i.br  = ($urandom_range(0, 3) == 0);
        i.jmp = ($urandom_range(0, 7) == 0);
        if (i.op == 3'd6) begin i.br = 1'b0; i.jmp = 1'b0; end
        i.rt = 5'($urandom); i.rd = 5'($urandom);
        return i;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, " xm_alu_result"}, xm_alu_result, 32'd0);
        chk({tag, " xm_store_data"}, xm_store_data, 32'd0);
        chk({tag, " xm_write_addr"}, {27'd0, xm_write_addr}, 32'd0);
        chk({tag, " ctrl"}, {27'd0, xm_valid, xm_mem_read, xm_mem_write, xm_reg_write, xm_mem_reg}, 32'd0);
        chk({tag, " branch_taken"}, {31'd0, branch_taken}, 32'd0);
        chk({tag, " branch_target"}, branch_target, 32'd0);
        chk({tag, " stall"}, {31'd0, stall}, 32'd0);
    endtask

    // Abort a multiply after ten steps with an asynchronous reset.
    task automatic reset_mid_mul();
        instr_t i;
        exp_t   e;
        i = blank(3'd6);
        i.rd0 = 32'd123; i.rd1 = 32'd456; i.rw = 1'b1; i.rt = 5'd4;
        apply(i);
        for (int c = 0; c <= 10; c++) begin
            e = '0;
            e.due = cyc + 1;
            sbq.push_back(e);
            #1 chk("stall(pre-reset)", {31'd0, stall}, MUL_EN ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        #1 rst = 1'b1;
        #1 chk_all_zero("mid-mul reset");
        sbq.delete();
        m_taken = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        instr_t i;
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        rst = 1'b0;

        // ADD with immediate
        i = blank(3'd0); i.rd0 = 32'd5; i.imm = 32'd7; i.src = 1'b1; i.rw = 1'b1; i.rt = 5'd9;
        run_instr(i);
        chk("add result", xm_alu_result, 32'd12);
        chk("add addr", {27'd0, xm_write_addr}, 32'd9);
        chk("add valid", {31'd0, xm_valid}, 32'd1);

        // beq taken, then the following instruction is squashed
        i = blank(3'd0); i.rd0 = 32'd3; i.rd1 = 32'd3; i.pc = 32'h100; i.imm = 32'd4; i.br = 1'b1;
        run_instr(i);
        chk("beq taken", {31'd0, branch_taken}, 32'd1);
        chk("beq target", branch_target, 32'h110);
        i = blank(3'd0); i.rw = 1'b1; i.rd0 = 32'd1;
        run_instr(i);
        chk("squash reg_write", {31'd0, xm_reg_write}, 32'd0);
        chk("squash valid", {31'd0, xm_valid}, 32'd0);

        // Signed compare and wrap-around subtract
        i = blank(3'd5); i.rd0 = 32'hFFFFFFFF; i.rd1 = 32'd1; i.rw = 1'b1;
        run_instr(i);
        chk("slt signed", xm_alu_result, 32'd1);
        i = blank(3'd2); i.rd0 = 32'd0; i.rd1 = 32'd1; i.rw = 1'b1;
        run_instr(i);
        chk("sub wrap", xm_alu_result, 32'hFFFFFFFF);

        // Jump wins over branch
        i = blank(3'd0); i.pc = 32'hA0000004; i.imm = 32'h40; i.br = 1'b1; i.jmp = 1'b1;
        i.rd0 = 32'd1; i.rd1 = 32'd2;
        run_instr(i);
        chk("jump taken", {31'd0, branch_taken}, 32'd1);
        chk("jump target", branch_target, 32'hA0000100);
        run_instr(blank(3'd0));

        // Multiplies, including back-to-back
        i = blank(3'd6); i.rd0 = 32'h10000; i.rd1 = 32'h10001; i.rw = 1'b1; i.rdst = 1'b1; i.rd = 5'd3;
        run_instr(i);
`ifdef EXECUTE_MUL_EN
        chk("mul result", xm_alu_result, 32'h00010000);
        chk("mul valid", {31'd0, xm_valid}, 32'd1);
`else
        chk("mul-as-noop valid", {31'd0, xm_valid}, 32'd0);
`endif
        i = blank(3'd6); i.rd0 = 32'd3; i.rd1 = 32'd5; i.rw = 1'b1; i.rt = 5'd7;
        run_instr(i);
        i.rd0 = 32'hFFFFFFFD; i.rd1 = 32'd9; i.mw = 1'b1;
        run_instr(i);

        // Reset during a multiply, idle afterwards, then a fresh multiply
        reset_mid_mul();
        for (int k = 0; k < 5; k++) run_instr(blank(3'd1));
        i = blank(3'd6); i.rd0 = 32'd6; i.rd1 = 32'd7; i.rw = 1'b1; i.rt = 5'd2;
        run_instr(i);
`ifdef EXECUTE_MUL_EN
        chk("mul after reset", xm_alu_result, 32'd42);
`else
        chk("mul-as-noop after reset", {31'd0, xm_valid}, 32'd0);
`endif

        // Randomized traffic
        for (int k = 0; k < 300; k++) run_instr(rand_instr());

        run_instr(blank(3'd1));
        run_instr(blank(3'd1));
        repeat (2) @(posedge clk);
        #1 chk("scoreboard drained", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
